// File: rtl/mem_master.sv
// Memory master: accepts single-word writes and 1..16-word burst reads,
// driving a memory with combinational read data and falling-edge writes.
module mem_master #(
  parameter int AW = 9,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [3:0]    req_len,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          wr_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_last_q, rsp_last_d;
  logic          wr_done_q, wr_done_d;

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_wr_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_wr_q    <= mem_wr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      wr_done_q   <= wr_done_d;
    end
  end

  // Next-state logic; pulses default low so they never outlive one cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_wr_d    = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    wr_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_addr_d = req_addr;
          if (req_wr) begin
            mem_din_d = req_data;
            mem_wr_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            cnt_d   = (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        wr_done_d = 1'b1;
        state_d   = IDLE;
      end
      READ: begin
        rsp_data_d  = mem_dout;
        rsp_valid_d = 1'b1;
        cnt_d       = cnt_q - 5'd1;
        // Address stays on the final word so it never runs past the burst
        if (cnt_q == 5'd1) begin
          rsp_last_d = 1'b1;
          state_d    = IDLE;
        end else begin
          mem_addr_d = mem_addr_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign wr_done   = wr_done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural memory:
// combinational read, write on the falling clock edge.
module tb_mem_master;

  localparam int AW = 9;
  localparam int DW = 12;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_len;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          wr_done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks;
  int errors;

  mem_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .wr_done(wr_done),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];
  always @(negedge clk) if (mem_wr) mem[mem_addr] = mem_din;

  // Advance past the next rising edge; outputs are stable 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({req_ready, mem_addr, mem_din, mem_wr, rsp_data, rsp_valid, rsp_last, wr_done}
        !== {1'b1, 9'd0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b a=%0d din=%0h wr=%b d=%0h v=%b l=%b wd=%b exp rdy=1 rest 0",
               req_ready, mem_addr, mem_din, mem_wr, rsp_data, rsp_valid, rsp_last, wr_done);
    end
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 9'o017; req_data = 12'o1234; req_len = 4'd5;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({mem_wr, mem_addr, mem_din, req_ready, wr_done} !== {1'b1, 9'o017, 12'o1234, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL write_issue got wr=%b a=%0o din=%0o rdy=%b wd=%b exp 1 17 1234 0 0",
               mem_wr, mem_addr, mem_din, req_ready, wr_done);
    end
    tick();
    checks++;
    if ({mem_wr, wr_done, req_ready} !== {1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL write_done got wr=%b wd=%b rdy=%b exp 0 1 1", mem_wr, wr_done, req_ready);
    end
    tick();
    checks++;
    if ({wr_done, mem[9'o017]} !== {1'b0, 12'o1234}) begin
      errors++;
      $display("FAIL write_mem got wd=%b mem=%0o exp 0 1234", wr_done, mem[9'o017]);
    end
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 9'o017; req_len = 4'd1;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({rsp_valid, mem_addr, req_ready} !== {1'b0, 9'o017, 1'b0}) begin
      errors++;
      $display("FAIL read1_issue got v=%b a=%0o rdy=%b exp 0 17 0", rsp_valid, mem_addr, req_ready);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_data, rsp_last, req_ready} !== {1'b1, 12'o1234, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL read1_beat got v=%b d=%0o l=%b rdy=%b exp 1 1234 1 1",
               rsp_valid, rsp_data, rsp_last, req_ready);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_last, rsp_data} !== {1'b0, 1'b0, 12'o1234}) begin
      errors++;
      $display("FAIL read1_after got v=%b l=%b d=%0o exp 0 0 1234", rsp_valid, rsp_last, rsp_data);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea;
    mem[510] = 12'o0001; mem[511] = 12'o0002; mem[0] = 12'o0003; mem[1] = 12'o0004;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 9'd510; req_len = 4'd4;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ea = 9'd510 + k[AW-1:0];
      checks++;
      if ({mem_addr, mem_wr} !== {ea, 1'b0}) begin
        errors++;
        $display("FAIL wrap_addr%0d got a=%0d wr=%b exp %0d 0", k, mem_addr, mem_wr, ea);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_data, rsp_last} !== {1'b1, 12'(k + 1), (k == 3)}) begin
        errors++;
        $display("FAIL wrap_beat%0d got v=%b d=%0d l=%b exp 1 %0d %b",
                 k, rsp_valid, rsp_data, rsp_last, k + 1, (k == 3));
      end
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ready got %b exp 1", req_ready);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_last, rsp_data} !== {1'b0, 1'b0, 12'd4}) begin
      errors++;
      $display("FAIL wrap_after got v=%b l=%b d=%0d exp 0 0 4", rsp_valid, rsp_last, rsp_data);
    end
  endtask

  task automatic test_len16();
    int ready_low;
    int beats;
    ready_low = 0;
    beats = 0;
    for (int k = 0; k < 16; k++) mem[9'o100 + k] = 12'(12'h0A0 + 3 * k);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 9'o100; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (req_ready == 1'b0) ready_low++;
      checks++;
      if (mem_addr !== 9'(9'o100 + k)) begin
        errors++;
        $display("FAIL len16_addr%0d got %0o exp %0o", k, mem_addr, 9'o100 + k);
      end
      tick();
      if (rsp_valid == 1'b1) beats++;
      checks++;
      if ({rsp_valid, rsp_data, rsp_last} !== {1'b1, 12'(12'h0A0 + 3 * k), (k == 15)}) begin
        errors++;
        $display("FAIL len16_beat%0d got v=%b d=%0h l=%b exp 1 %0h %b",
                 k, rsp_valid, rsp_data, rsp_last, 12'h0A0 + 3 * k, (k == 15));
      end
    end
    tick();
    checks++;
    if ({ready_low, beats, rsp_valid, req_ready} !== {32'd16, 32'd16, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL len16_count got low=%0d beats=%0d v=%b rdy=%b exp 16 16 0 1",
               ready_low, beats, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) mem[9'd200 + k] = 12'(12'h500 + k);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 9'd200; req_len = 4'd8;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 12'h501}) begin
      errors++;
      $display("FAIL rstmid_beat2 got v=%b d=%0h exp 1 501", rsp_valid, rsp_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({req_ready, mem_addr, mem_din, mem_wr, rsp_data, rsp_valid, rsp_last, wr_done}
        !== {1'b1, 9'd0, 12'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_state got rdy=%b a=%0d din=%0h wr=%b d=%0h v=%b l=%b wd=%b exp rdy=1 rest 0",
               req_ready, mem_addr, mem_din, mem_wr, rsp_data, rsp_valid, rsp_last, wr_done);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({rsp_valid, rsp_last, req_ready} !== {1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL rstmid_quiet%0d got v=%b l=%b rdy=%b exp 0 0 1", k, rsp_valid, rsp_last, req_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    mem[9'd300] = 12'h111; mem[9'd301] = 12'h222; mem[9'd302] = 12'h333;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 9'd300; req_len = 4'd3;
    tick();
    req_wr = 1'b1; req_addr = 9'd77; req_data = 12'hBEE;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({req_ready, mem_wr} !== {1'b0, 1'b0}) begin
        errors++;
        $display("FAIL b2b_busy%0d got rdy=%b wr=%b exp 0 0", k, req_ready, mem_wr);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_data, rsp_last, mem_wr} !== {1'b1, 12'(12'h111 * (k + 1)), (k == 2), 1'b0}) begin
        errors++;
        $display("FAIL b2b_beat%0d got v=%b d=%0h l=%b wr=%b exp 1 %0h %b 0",
                 k, rsp_valid, rsp_data, rsp_last, mem_wr, 12'h111 * (k + 1), (k == 2));
      end
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if ({mem_wr, mem_addr, mem_din, rsp_valid} !== {1'b1, 9'd77, 12'hBEE, 1'b0}) begin
      errors++;
      $display("FAIL b2b_write got wr=%b a=%0d din=%0h v=%b exp 1 77 bee 0", mem_wr, mem_addr, mem_din, rsp_valid);
    end
    tick();
    checks++;
    if ({mem_wr, wr_done, mem[9'd77]} !== {1'b0, 1'b1, 12'hBEE}) begin
      errors++;
      $display("FAIL b2b_done got wr=%b wd=%b mem=%0h exp 0 1 bee", mem_wr, wr_done, mem[9'd77]);
    end
  endtask

  task automatic test_reset_req();
    mem[9'd40] = 12'h0;
    rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 9'd40; req_data = 12'hABC;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_wr, rsp_valid, wr_done, req_ready} !== {1'b0, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL rstreq_quiet%0d got wr=%b v=%b wd=%b rdy=%b exp 0 0 0 1",
                 k, mem_wr, rsp_valid, wr_done, req_ready);
      end
      tick();
    end
    checks++;
    if (mem[9'd40] !== 12'h0) begin
      errors++;
      $display("FAIL rstreq_mem got %0h exp 0", mem[9'd40]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_len = 4'd0; req_data = '0;
    #1;
    test_reset();
    test_write_read();
    test_wrap();
    test_len16();
    test_reset_mid();
    test_back_to_back();
    test_reset_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
